// File: rtl/volatility_window_ctrl.sv
// Per-stock circular window writer for the volatility buffer RAM, with an oldest-to-newest read sweep.
// The sweep engine is built only when VOLATILITY_SWEEP_EN is defined; otherwise only writes and fill tracking exist.
module volatility_window_ctrl #(
  parameter  int NUM_STOCKS = 4,
  parameter  int MAX_DEPTH  = 32,
  parameter  int DATA_WIDTH = 32,
  localparam int SID_W      = $clog2(NUM_STOCKS),
  localparam int ADDR_W     = $clog2(NUM_STOCKS*MAX_DEPTH),
  localparam int DEPTH_W    = $clog2(MAX_DEPTH+1)
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_cfg_valid,
  input  logic [DEPTH_W-1:0]            i_window_depth,
  input  logic                          i_data_valid,
  input  logic [SID_W-1:0]              i_stock_id,
  input  logic [DATA_WIDTH-1:0]         i_data,
  output logic                          o_ready,
  output logic                          o_wr_en,
  output logic [ADDR_W-1:0]             o_wr_addr,
  output logic [DATA_WIDTH-1:0]         o_wr_data,
  output logic                          o_rd_en,
  output logic [ADDR_W-1:0]             o_rd_addr,
  output logic [SID_W-1:0]              o_rd_stock_id,
  output logic                          o_rd_last,
  output logic [NUM_STOCKS-1:0]         o_window_full,
  output logic [NUM_STOCKS*DEPTH_W-1:0] o_fill_count
);

  localparam logic [SID_W:0] NUM_STOCKS_X = (SID_W+1)'(NUM_STOCKS);

  function automatic logic [DEPTH_W-1:0] clamp_depth(input logic [DEPTH_W-1:0] d);
    if (d < DEPTH_W'(2))              return DEPTH_W'(2);
    else if (d > DEPTH_W'(MAX_DEPTH)) return DEPTH_W'(MAX_DEPTH);
    return d;
  endfunction

  function automatic logic [ADDR_W-1:0] region_addr(input logic [SID_W-1:0] sid,
                                                    input logic [DEPTH_W-1:0] ptr);
    return ADDR_W'(sid) * ADDR_W'(MAX_DEPTH) + ADDR_W'(ptr);
  endfunction

  function automatic logic [DEPTH_W-1:0] next_ptr(input logic [DEPTH_W-1:0] ptr,
                                                  input logic [DEPTH_W-1:0] depth);
    return (ptr == depth - DEPTH_W'(1)) ? '0 : ptr + DEPTH_W'(1);
  endfunction

  logic [DEPTH_W-1:0]    depth_q, depth_d;
  logic [DEPTH_W-1:0]    wr_ptr_q [NUM_STOCKS];
  logic [DEPTH_W-1:0]    wr_ptr_d [NUM_STOCKS];
  logic [DEPTH_W-1:0]    fill_q   [NUM_STOCKS];
  logic [DEPTH_W-1:0]    fill_d   [NUM_STOCKS];
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  sid_ok;
  logic                  accept;

  // Out-of-range stock IDs are accepted on the handshake but otherwise ignored.
  assign sid_ok = ({1'b0, i_stock_id} < NUM_STOCKS_X);
  assign accept = i_data_valid && o_ready;

  always_comb begin
    depth_d   = depth_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    for (int i = 0; i < NUM_STOCKS; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      fill_d[i]   = fill_q[i];
    end
    if (i_cfg_valid) begin
      depth_d = clamp_depth(i_window_depth);
      for (int i = 0; i < NUM_STOCKS; i++) begin
        wr_ptr_d[i] = '0;
        fill_d[i]   = '0;
      end
    end else if (accept && sid_ok) begin
      wr_en_d              = 1'b1;
      wr_addr_d            = region_addr(i_stock_id, wr_ptr_q[i_stock_id]);
      wr_data_d            = i_data;
      wr_ptr_d[i_stock_id] = next_ptr(wr_ptr_q[i_stock_id], depth_q);
      fill_d[i_stock_id]   = (fill_q[i_stock_id] == depth_q) ? depth_q
                                                             : fill_q[i_stock_id] + DEPTH_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      depth_q   <= DEPTH_W'(MAX_DEPTH);
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < NUM_STOCKS; i++) begin
        wr_ptr_q[i] <= '0;
        fill_q[i]   <= '0;
      end
    end else begin
      depth_q   <= depth_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      for (int i = 0; i < NUM_STOCKS; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        fill_q[i]   <= fill_d[i];
      end
    end
  end

  assign o_wr_en   = wr_en_q;
  assign o_wr_addr = wr_addr_q;
  assign o_wr_data = wr_data_q;

  always_comb begin
    o_fill_count  = '0;
    o_window_full = '0;
    for (int i = 0; i < NUM_STOCKS; i++) begin
      o_fill_count[i*DEPTH_W +: DEPTH_W] = fill_q[i];
      o_window_full[i]                   = (fill_q[i] == depth_q);
    end
  end

`ifdef VOLATILITY_SWEEP_EN
  typedef enum logic {IDLE, SWEEP} state_t;

  state_t             state_q, state_d;
  logic [DEPTH_W-1:0] sw_ptr_q, sw_ptr_d;
  logic [DEPTH_W-1:0] sw_idx_q, sw_idx_d;
  logic [SID_W-1:0]   rd_sid_q, rd_sid_d;
  logic               rd_en_q, rd_en_d;
  logic               rd_last_q, rd_last_d;

  assign o_ready = (state_q == IDLE) && !i_cfg_valid;

  // sw_idx counts reads issued so far; the read that brings it to depth is the last.
  always_comb begin
    state_d   = state_q;
    sw_ptr_d  = sw_ptr_q;
    sw_idx_d  = sw_idx_q;
    rd_sid_d  = rd_sid_q;
    rd_en_d   = 1'b0;
    rd_last_d = 1'b0;
    if (i_cfg_valid) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && sid_ok && (fill_d[i_stock_id] == depth_q)) begin
            state_d  = SWEEP;
            rd_en_d  = 1'b1;
            rd_sid_d = i_stock_id;
            sw_ptr_d = wr_ptr_d[i_stock_id];
            sw_idx_d = DEPTH_W'(1);
          end
        end
        SWEEP: begin
          if (rd_last_q) begin
            state_d = IDLE;
          end else begin
            rd_en_d   = 1'b1;
            sw_ptr_d  = next_ptr(sw_ptr_q, depth_q);
            sw_idx_d  = sw_idx_q + DEPTH_W'(1);
            rd_last_d = (sw_idx_q + DEPTH_W'(1) == depth_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      sw_ptr_q  <= '0;
      sw_idx_q  <= '0;
      rd_sid_q  <= '0;
      rd_en_q   <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sw_ptr_q  <= sw_ptr_d;
      sw_idx_q  <= sw_idx_d;
      rd_sid_q  <= rd_sid_d;
      rd_en_q   <= rd_en_d;
      rd_last_q <= rd_last_d;
    end
  end

  assign o_rd_en       = rd_en_q;
  assign o_rd_addr     = region_addr(rd_sid_q, sw_ptr_q);
  assign o_rd_stock_id = rd_sid_q;
  assign o_rd_last     = rd_last_q;
`else
  assign o_ready       = !i_cfg_valid;
  assign o_rd_en       = 1'b0;
  assign o_rd_addr     = '0;
  assign o_rd_stock_id = '0;
  assign o_rd_last     = 1'b0;
`endif

endmodule

// File: tb/tb_volatility_window_ctrl.sv
// Bench for volatility_window_ctrl: directed scenarios plus a randomized run against a
// sample-count window model; sweep expectations follow VOLATILITY_SWEEP_EN.
`timescale 1ns/1ps
module tb_volatility_window_ctrl;
  localparam int NS = 4, MD = 32, DW = 32;
  localparam int SID_W = 2, ADDR_W = 7, DEPTH_W = 6;
`ifdef VOLATILITY_SWEEP_EN
  localparam bit SWEEP_EN = 1'b1;
`else
  localparam bit SWEEP_EN = 1'b0;
`endif

  logic                  i_clk = 1'b0;
  logic                  i_reset = 1'b1;
  logic                  i_cfg_valid = 1'b0;
  logic [DEPTH_W-1:0]    i_window_depth = '0;
  logic                  i_data_valid = 1'b0;
  logic [SID_W-1:0]      i_stock_id = '0;
  logic [DW-1:0]         i_data = '0;
  logic                  o_ready, o_wr_en, o_rd_en, o_rd_last;
  logic [ADDR_W-1:0]     o_wr_addr, o_rd_addr;
  logic [DW-1:0]         o_wr_data;
  logic [SID_W-1:0]      o_rd_stock_id;
  logic [NS-1:0]         o_window_full;
  logic [NS*DEPTH_W-1:0] o_fill_count;

  int vectors = 0;
  int miscompares = 0;

  volatility_window_ctrl #(.NUM_STOCKS(NS), .MAX_DEPTH(MD), .DATA_WIDTH(DW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_cfg_valid(i_cfg_valid), .i_window_depth(i_window_depth),
    .i_data_valid(i_data_valid), .i_stock_id(i_stock_id), .i_data(i_data), .o_ready(o_ready),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_rd_en(o_rd_en),
    .o_rd_addr(o_rd_addr), .o_rd_stock_id(o_rd_stock_id), .o_rd_last(o_rd_last),
    .o_window_full(o_window_full), .o_fill_count(o_fill_count)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Window model: a window is defined by the number of samples seen since the last config.
  int m_depth;
  int m_cnt [NS];
  int m_rdq [$];
  int m_rd_sid;

  function automatic int clampd(int d);
    return (d < 2) ? 2 : ((d > MD) ? MD : d);
  endfunction

  function automatic void m_config(int d);
    m_depth = clampd(d);
    for (int i = 0; i < NS; i++) m_cnt[i] = 0;
    m_rdq.delete();
  endfunction

  function automatic int m_accept(int s);
    int a;
    a = s*MD + (m_cnt[s] % m_depth);
    m_cnt[s]++;
    if (SWEEP_EN && m_cnt[s] >= m_depth) begin
      m_rd_sid = s;
      for (int k = 0; k < m_depth; k++) m_rdq.push_back(s*MD + ((m_cnt[s] - m_depth + k) % m_depth));
    end
    return a;
  endfunction

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic drive(bit cfg, int d, bit dv, int s, logic [DW-1:0] v);
    i_cfg_valid = cfg; i_window_depth = DEPTH_W'(d);
    i_data_valid = dv; i_stock_id = SID_W'(s); i_data = v;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, '0);
    i_reset = 1'b1;
    tick(); tick();
    vectors++; if (o_wr_en !== 1'b0)       begin miscompares++; $display("FAIL reset_wr_en got %b want 0", o_wr_en); end
    vectors++; if (o_wr_addr !== '0)       begin miscompares++; $display("FAIL reset_wr_addr got %0d want 0", o_wr_addr); end
    vectors++; if (o_wr_data !== '0)       begin miscompares++; $display("FAIL reset_wr_data got %h want 0", o_wr_data); end
    vectors++; if (o_rd_en !== 1'b0 || o_rd_last !== 1'b0 || o_rd_addr !== '0 || o_rd_stock_id !== '0)
      begin miscompares++; $display("FAIL reset_rd got en=%b last=%b addr=%0d sid=%0d want all 0", o_rd_en, o_rd_last, o_rd_addr, o_rd_stock_id); end
    vectors++; if (o_fill_count !== '0 || o_window_full !== '0)
      begin miscompares++; $display("FAIL reset_fill got fill=%h full=%b want 0", o_fill_count, o_window_full); end
    vectors++; if (o_ready !== 1'b1)       begin miscompares++; $display("FAIL reset_ready got %b want 1", o_ready); end
    i_reset = 1'b0;
    m_config(MD);
    tick();
  endtask

  task automatic test_basic_writes();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 2, DW'(32'h100 + k));
      #1;
      vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL basic_ready[%0d] got %b want 1", k, o_ready); end
      tick();
      vectors++; if (o_wr_en !== 1'b1 || o_wr_addr !== ADDR_W'(64 + k) || o_wr_data !== DW'(32'h100 + k))
        begin miscompares++; $display("FAIL basic_write[%0d] got en=%b addr=%0d data=%h want 1/%0d/%h", k, o_wr_en, o_wr_addr, o_wr_data, 64 + k, 32'h100 + k); end
      vectors++; if (o_rd_en !== 1'b0) begin miscompares++; $display("FAIL basic_no_read[%0d] got %b want 0", k, o_rd_en); end
    end
    drive(0, 0, 0, 0, '0);
    tick();
    vectors++; if (o_fill_count[2*DEPTH_W +: DEPTH_W] !== DEPTH_W'(3) || o_window_full !== '0 || o_wr_en !== 1'b0)
      begin miscompares++; $display("FAIL basic_fill got fill2=%0d full=%b wr_en=%b want 3/0/0", o_fill_count[2*DEPTH_W +: DEPTH_W], o_window_full, o_wr_en); end
  endtask

`ifdef VOLATILITY_SWEEP_EN
  task automatic test_sweep();
    int exp5 [4];
    exp5 = '{33, 34, 35, 32};
    drive(1, 4, 1, 1, 32'hDEAD);
    #1;
    vectors++; if (o_ready !== 1'b0) begin miscompares++; $display("FAIL sweep_cfg_ready got %b want 0", o_ready); end
    tick();
    vectors++; if (o_wr_en !== 1'b0) begin miscompares++; $display("FAIL sweep_cfg_sample_dropped got wr_en=%b want 0", o_wr_en); end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, 1, DW'(k + 1));
      tick();
      vectors++; if (o_wr_en !== 1'b1 || o_wr_addr !== ADDR_W'(32 + k))
        begin miscompares++; $display("FAIL sweep_write[%0d] got en=%b addr=%0d want 1/%0d", k, o_wr_en, o_wr_addr, 32 + k); end
    end
    drive(0, 0, 1, 0, 32'h77);
    for (int j = 0; j < 4; j++) begin
      #1;
      vectors++; if (o_rd_en !== 1'b1 || o_rd_addr !== ADDR_W'(32 + j) || o_rd_last !== (j == 3) || o_rd_stock_id !== 2'd1 || o_ready !== 1'b0)
        begin miscompares++; $display("FAIL sweep_read[%0d] got en=%b addr=%0d last=%b sid=%0d rdy=%b want 1/%0d/%0d/1/0", j, o_rd_en, o_rd_addr, o_rd_last, o_rd_stock_id, o_ready, 32 + j, j == 3); end
      if (j == 3) drive(0, 0, 0, 0, '0);
      tick();
    end
    vectors++; if (o_rd_en !== 1'b0 || o_ready !== 1'b1 || o_wr_en !== 1'b0 || o_fill_count[0 +: DEPTH_W] !== '0)
      begin miscompares++; $display("FAIL sweep_end got rd_en=%b rdy=%b wr_en=%b fill0=%0d want 0/1/0/0", o_rd_en, o_ready, o_wr_en, o_fill_count[0 +: DEPTH_W]); end
    drive(0, 0, 1, 1, 32'hA5);
    tick();
    drive(0, 0, 0, 0, '0);
    vectors++; if (o_wr_en !== 1'b1 || o_wr_addr !== ADDR_W'(32) || o_wr_data !== DW'(32'hA5))
      begin miscompares++; $display("FAIL sweep_wrap_write got en=%b addr=%0d data=%h want 1/32/a5", o_wr_en, o_wr_addr, o_wr_data); end
    for (int j = 0; j < 4; j++) begin
      vectors++; if (o_rd_en !== 1'b1 || o_rd_addr !== ADDR_W'(exp5[j]) || o_rd_last !== (j == 3))
        begin miscompares++; $display("FAIL sweep_wrap_read[%0d] got en=%b addr=%0d last=%b want 1/%0d/%0d", j, o_rd_en, o_rd_addr, o_rd_last, exp5[j], j == 3); end
      tick();
    end
  endtask

  task automatic test_cfg_abort();
    drive(1, 8, 0, 0, '0);
    tick();
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 1, 0, DW'(k));
      tick();
    end
    drive(0, 0, 0, 0, '0);
    tick();
    vectors++; if (o_rd_en !== 1'b1 || o_rd_addr !== ADDR_W'(1))
      begin miscompares++; $display("FAIL abort_second_read got en=%b addr=%0d want 1/1", o_rd_en, o_rd_addr); end
    drive(1, 8, 0, 0, '0);
    tick();
    drive(0, 0, 0, 0, '0);
    #1;
    vectors++; if (o_rd_en !== 1'b0 || o_fill_count !== '0 || o_ready !== 1'b1)
      begin miscompares++; $display("FAIL abort_after got rd_en=%b fill=%h rdy=%b want 0/0/1", o_rd_en, o_fill_count, o_ready); end
    tick();
  endtask

  task automatic test_async_reset_sweep();
    drive(1, 4, 0, 0, '0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, 2, DW'(k));
      tick();
    end
    drive(0, 0, 0, 0, '0);
    #2;
    i_reset = 1'b1;
    #1;
    vectors++; if (o_rd_en !== 1'b0 || o_wr_en !== 1'b0 || o_rd_last !== 1'b0 || o_fill_count !== '0)
      begin miscompares++; $display("FAIL async_reset_immediate got rd_en=%b wr_en=%b last=%b fill=%h want 0/0/0/0", o_rd_en, o_wr_en, o_rd_last, o_fill_count); end
    tick();
    i_reset = 1'b0;
    m_config(MD);
    for (int c = 0; c < 5; c++) begin
      tick();
      vectors++; if (o_rd_en !== 1'b0 || o_ready !== 1'b1)
        begin miscompares++; $display("FAIL async_reset_quiet[%0d] got rd_en=%b rdy=%b want 0/1", c, o_rd_en, o_ready); end
    end
  endtask
`else
  task automatic test_no_sweep();
    drive(1, 4, 0, 0, '0);
    tick();
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 1, 3, DW'(k + 9));
      #1;
      vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL nosweep_ready[%0d] got %b want 1", k, o_ready); end
      tick();
      vectors++; if (o_wr_en !== 1'b1 || o_wr_addr !== ADDR_W'(96 + (k % 4)) || o_rd_en !== 1'b0)
        begin miscompares++; $display("FAIL nosweep_write[%0d] got en=%b addr=%0d rd_en=%b want 1/%0d/0", k, o_wr_en, o_wr_addr, o_rd_en, 96 + (k % 4)); end
    end
    drive(0, 0, 0, 0, '0);
    tick();
  endtask
`endif

  task automatic test_clamp();
    drive(1, 0, 0, 0, '0);
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 1, 0, DW'(k));
      tick();
      vectors++; if (o_wr_en !== 1'b1 || o_wr_addr !== ADDR_W'(k))
        begin miscompares++; $display("FAIL clamp2_write[%0d] got en=%b addr=%0d want 1/%0d", k, o_wr_en, o_wr_addr, k); end
    end
    drive(0, 0, 0, 0, '0);
    vectors++; if (o_fill_count[0 +: DEPTH_W] !== DEPTH_W'(2) || o_window_full[0] !== 1'b1)
      begin miscompares++; $display("FAIL clamp2_full got fill0=%0d full0=%b want 2/1", o_fill_count[0 +: DEPTH_W], o_window_full[0]); end
`ifdef VOLATILITY_SWEEP_EN
    for (int j = 0; j < 2; j++) begin
      vectors++; if (o_rd_en !== 1'b1 || o_rd_addr !== ADDR_W'(j) || o_rd_last !== (j == 1))
        begin miscompares++; $display("FAIL clamp2_read[%0d] got en=%b addr=%0d last=%b want 1/%0d/%0d", j, o_rd_en, o_rd_addr, o_rd_last, j, j == 1); end
      tick();
    end
`endif
    drive(1, 40, 0, 0, '0);
    tick();
    for (int k = 0; k < 32; k++) begin
      drive(0, 0, 1, 3, DW'(k));
      #1;
      vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL clamp32_ready[%0d] got %b want 1", k, o_ready); end
      tick();
    end
    drive(0, 0, 0, 0, '0);
    vectors++; if (o_fill_count[3*DEPTH_W +: DEPTH_W] !== DEPTH_W'(32) || o_window_full[3] !== 1'b1 || o_wr_addr !== ADDR_W'(127))
      begin miscompares++; $display("FAIL clamp32_full got fill3=%0d full3=%b addr=%0d want 32/1/127", o_fill_count[3*DEPTH_W +: DEPTH_W], o_window_full[3], o_wr_addr); end
  endtask

  task automatic test_random();
    int rd_active, s, d, ea, ra;
    bit do_cfg, dv, exp_ready, acc, exp_wr, exp_rd, exp_last;
    logic [DW-1:0] v;
    logic [NS*DEPTH_W-1:0] ef;
    logic [NS-1:0] efull;
    drive(1, 4, 0, 0, '0);
    m_config(4);
    tick();
    rd_active = 0;
    for (int it = 0; it < 400; it++) begin
      do_cfg = ($urandom_range(0, 24) == 0);
      d  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(2, 6)) : int'($urandom_range(0, 40));
      dv = ($urandom_range(0, 3) != 0);
      s  = $urandom_range(0, NS-1);
      v  = $urandom;
      drive(do_cfg, d, dv, s, v);
      #1;
      exp_ready = (rd_active == 0) && !do_cfg;
      vectors++; if (o_ready !== exp_ready) begin miscompares++; $display("FAIL rand_ready[%0d] got %b want %b", it, o_ready, exp_ready); end
      acc = dv && exp_ready;
      exp_wr = 1'b0; ea = 0;
      if (do_cfg) m_config(d);
      else if (acc) begin exp_wr = 1'b1; ea = m_accept(s); end
      @(posedge i_clk); #1;
      exp_rd = 1'b0; exp_last = 1'b0; ra = 0;
      if (m_rdq.size() > 0) begin
        exp_rd = 1'b1; ra = m_rdq.pop_front(); exp_last = (m_rdq.size() == 0);
      end
      rd_active = exp_rd;
      vectors++; if (o_wr_en !== exp_wr || (exp_wr && (o_wr_addr !== ADDR_W'(ea) || o_wr_data !== v)))
        begin miscompares++; $display("FAIL rand_write[%0d] got en=%b addr=%0d data=%h want %b/%0d/%h", it, o_wr_en, o_wr_addr, o_wr_data, exp_wr, ea, v); end
      vectors++; if (o_rd_en !== exp_rd || (exp_rd && (o_rd_addr !== ADDR_W'(ra) || o_rd_last !== exp_last || o_rd_stock_id !== SID_W'(m_rd_sid))))
        begin miscompares++; $display("FAIL rand_read[%0d] got en=%b addr=%0d last=%b sid=%0d want %b/%0d/%b/%0d", it, o_rd_en, o_rd_addr, o_rd_last, o_rd_stock_id, exp_rd, ra, exp_last, m_rd_sid); end
      for (int i = 0; i < NS; i++) begin
        ef[i*DEPTH_W +: DEPTH_W] = DEPTH_W'((m_cnt[i] < m_depth) ? m_cnt[i] : m_depth);
        efull[i] = (m_cnt[i] >= m_depth);
      end
      vectors++; if (o_fill_count !== ef || o_window_full !== efull)
        begin miscompares++; $display("FAIL rand_fill[%0d] got fill=%h full=%b want %h/%b", it, o_fill_count, o_window_full, ef, efull); end
    end
    drive(0, 0, 0, 0, '0);
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_writes();
`ifdef VOLATILITY_SWEEP_EN
    test_sweep();
`else
    test_no_sweep();
`endif
    test_clamp();
`ifdef VOLATILITY_SWEEP_EN
    test_cfg_abort();
    test_async_reset_sweep();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/volatility_window_ctrl.md
# volatility_window_ctrl

Per-stock sliding-window controller for the volatility buffer RAM. Accepts incoming price samples tagged with a stock ID and writes each one into that stock's circular window region. Tracks per-stock fill level and a runtime-configurable window depth. Once a stock's window is full, every new sample triggers a read sweep of the whole window, oldest to newest, which feeds the downstream variance datapath.

## Interface
Parameters:
- NUM_STOCKS, 4, number of independent stock windows
- MAX_DEPTH, 32, samples per stock region; region base = stock_id*MAX_DEPTH
- DATA_WIDTH, 32, sample width
- Derived: SID_W = $clog2(NUM_STOCKS), ADDR_W = $clog2(NUM_STOCKS*MAX_DEPTH), DEPTH_W = $clog2(MAX_DEPTH+1)

Ports:
- i_clk  in  1  clock
- i_reset  in  1  **asynchronous, active-high reset**
- i_cfg_valid  in  1  load new window depth and clear all windows
- i_window_depth  in  DEPTH_W  requested depth
- i_data_valid  in  1  sample present
- i_stock_id  in  SID_W  sample's stock
- i_data  in  DATA_WIDTH  sample value
- o_ready  out  1  sample accepted when i_data_valid && o_ready
- o_wr_en  out  1  RAM write strobe
- o_wr_addr  out  ADDR_W  RAM write address
- o_wr_data  out  DATA_WIDTH  RAM write data
- o_rd_en  out  1  sweep read strobe
- o_rd_addr  out  ADDR_W  sweep read address
- o_rd_stock_id  out  SID_W  stock being swept
- o_rd_last  out  1  final read of the sweep
- o_window_full  out  NUM_STOCKS  per-stock full flag
- o_fill_count  out  NUM_STOCKS*DEPTH_W  per-stock fill level, stock i at [i*DEPTH_W +: DEPTH_W]

## Operation
- State: per-stock wr_ptr (0..depth-1), per-stock fill (0..depth), latched depth, FSM {IDLE, SWEEP}, sweep index, sweep pointer.
- Depth clamp on load: values <2 become 2; values >MAX_DEPTH become MAX_DEPTH.
- Reset: depth=MAX_DEPTH, all wr_ptr/fill=0, FSM=IDLE, all outputs 0 except o_ready (combinational, 1 after reset).
- o_ready = (state==IDLE) && !i_cfg_valid.
- Accepted sample for stock s:
  - Write address = s*MAX_DEPTH + wr_ptr[s].
  - wr_ptr[s] wraps to 0 when it equals depth-1, otherwise increments.
  - fill[s] saturates at depth.
- Stock ID ≥ NUM_STOCKS: the sample is accepted and dropped. No write and no state change.
- Sweep: triggered when fill[s] equals depth after the update.
  - Issues depth reads of stock s, starting at the updated wr_ptr[s] (the oldest entry).
  - Address wraps within the region, one read per cycle.
  - o_rd_last asserts on the depth-th read. FSM then returns to IDLE.
- Config (i_cfg_valid): takes priority over everything, in any state.
  - Clears all wr_ptr and fill, latches the clamped depth, aborts any sweep (FSM=IDLE, o_rd_en=0 next cycle).
  - A sample presented in the same cycle is not accepted.

## Timing
- Write latency 1: sample accepted at T gives o_wr_en/o_wr_addr/o_wr_data at T+1 (registered).
- Sweep: reads at T+1..T+depth. o_rd_last at T+depth. o_ready low over T+1..T+depth, high again at T+depth+1.
  - Because depth≥2, the T+1 read address never equals the T+1 write address.
- Back-to-back samples are accepted every cycle while no sweep is triggered.
- o_fill_count/o_window_full are registered and reflect accepted samples one cycle after acceptance.
- Asynchronous reset mid-sweep: all strobes drop immediately, and no further reads are issued.

## Configuration
- VOLATILITY_SWEEP_EN:
  - Defined: the sweep FSM is present as described above.
  - Undefined: no sweep logic. o_rd_en/o_rd_addr/o_rd_stock_id/o_rd_last are tied to 0, o_ready = !i_cfg_valid, and the FSM is absent. Write/fill behaviour is unchanged.

## Test plan
- Reset then 3 samples to stock 2 (MAX_DEPTH=32, depth 32) -> writes at addresses 64, 65, 66, one cycle after each acceptance. fill[2]=3, no reads.
- Config depth 4, then 4 samples to stock 1 -> writes 32..35. After the 4th: reads 32, 33, 34, 35 on the next 4 cycles, o_rd_last on 35, o_ready low for exactly 4 cycles.
- Continue with a 5th sample to stock 1 (value 0xA5) -> write at 32 with data 0xA5. Sweep reads 33, 34, 35, 32.
- Config depth 0 and then 40 -> latched depth 2 and 32 respectively. Two samples to stock 0 at depth 2 -> writes 0, 1, then a 2-read sweep 0, 1.
- i_cfg_valid asserted on the 2nd cycle of a depth-8 sweep -> o_rd_en low the next cycle. All fill counts become 0 and o_ready returns high.
- Without VOLATILITY_SWEEP_EN, depth 4 and 6 samples to stock 3 -> writes 96, 97, 98, 99, 96, 97. o_rd_en never asserts, o_ready stays 1.
